// File: rtl/audio_tone_arbiter.sv
// Fixed-priority arbiter that shares one CODEC write channel between tone requesters.
// The block plays a square wave of +/-AMPLITUDE and supports preemption by higher-priority requesters.
module audio_tone_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter int          PERIOD_W  = 16,
  parameter int          DUR_W     = 20,
  parameter logic [23:0] AMPLITUDE = 24'h0FFFFF,
  localparam int         ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*PERIOD_W-1:0]  req_half_period,
  input  logic [NUM_REQ*DUR_W-1:0]     req_duration,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic [ID_W-1:0]              active_id,
  output logic                         done,
  output logic                         aborted,
  input  logic                         write_ready,
  output logic                         write,
  output logic [23:0]                  writedata_left,
  output logic [23:0]                  writedata_right
);

  localparam logic [23:0] AMP_NEG = ~AMPLITUDE + 24'd1;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] half_q, half_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [DUR_W-1:0]    rem_q, rem_d;
  logic                phase_q, phase_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic [23:0]         data_q, data_d;

  logic [PERIOD_W-1:0] hp_slot  [NUM_REQ];
  logic [DUR_W-1:0]    dur_slot [NUM_REQ];
  logic [ID_W-1:0]     win_idx;
  logic                req_any;
  logic                preempt;
  logic                accept;
  logic                load;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign hp_slot[g]  = req_half_period[g*PERIOD_W +: PERIOD_W];
    assign dur_slot[g] = req_duration[g*DUR_W +: DUR_W];
  end

  // Lowest requesting index wins; scanning downward leaves the smallest set bit.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_idx = ID_W'(i);
    end
  end

  assign req_any = |req;
  assign preempt = (state_q == PLAY) && req_any && (win_idx < id_q);
  assign load    = ((state_q == IDLE) && req_any) || preempt;

  // Handshake: write is a valid strobe that is only raised when write_ready is
  // already high, so every cycle with write high transfers exactly one sample.
  assign accept = (state_q == PLAY) && write_ready;

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    phase_d   = phase_q;
    id_d      = id_q;
    grant_d   = '0;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    if (load) begin
      aborted_d = preempt;
      grant_d   = NUM_REQ'(1) << win_idx;
      id_d      = win_idx;
      half_d    = hp_slot[win_idx];
      rem_d     = dur_slot[win_idx];
      phase_d   = 1'b1;
      cnt_d     = '0;
      if ((hp_slot[win_idx] != '0) && (dur_slot[win_idx] != '0)) begin
        state_d = PLAY;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (accept) begin
      rem_d = rem_q - DUR_W'(1);
      if (rem_q == DUR_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (cnt_q == half_q - PERIOD_W'(1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end

    // Sample register tracks the phase that the next accepted sample will carry.
    data_d = (state_d == PLAY) ? (phase_d ? AMPLITUDE : AMP_NEG) : 24'd0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      half_q    <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      phase_q   <= 1'b0;
      id_q      <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      phase_q   <= phase_d;
      id_q      <= id_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      data_q    <= data_d;
    end
  end

  assign grant           = grant_q;
  assign busy            = (state_q == PLAY);
  assign active_id       = id_q;
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign write           = busy && write_ready;
  assign writedata_left  = data_q;
  assign writedata_right = data_q;

endmodule

// File: tb/tb_audio_tone_arbiter.sv
// Self-checking bench for audio_tone_arbiter: vector table, directed corner sequences,
// and randomized traffic against a sample-index reference model.
module tb_audio_tone_arbiter;

  localparam int          NUM_REQ  = 4;
  localparam int          PERIOD_W = 16;
  localparam int          DUR_W    = 20;
  localparam logic [23:0] AMP      = 24'h0FFFFF;
  localparam logic [23:0] NEG      = 24'hF00001;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*PERIOD_W-1:0] hp_bus;
  logic [NUM_REQ*DUR_W-1:0]    dur_bus;
  logic                        write_ready;
  logic [NUM_REQ-1:0]          grant;
  logic                        busy;
  logic [1:0]                  active_id;
  logic                        done;
  logic                        aborted;
  logic                        write;
  logic [23:0]                 writedata_left;
  logic [23:0]                 writedata_right;

  always #5 clk = ~clk;

  audio_tone_arbiter dut (
    .CLOCK_50        (clk),
    .reset           (reset),
    .req             (req),
    .req_half_period (hp_bus),
    .req_duration    (dur_bus),
    .grant           (grant),
    .busy            (busy),
    .active_id       (active_id),
    .done            (done),
    .aborted         (aborted),
    .write_ready     (write_ready),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a tone is just (id, half period, duration, samples sent).
  logic               m_busy    = 1'b0;
  int                 m_id      = 0;
  int                 m_sent    = 0;
  int                 m_half    = 0;
  int                 m_dur     = 0;
  logic [NUM_REQ-1:0] m_grant   = '0;
  logic               m_done    = 1'b0;
  logic               m_aborted = 1'b0;

  logic [23:0] exp_q[$];
  logic        sb_on = 1'b0;

  typedef struct {
    logic [3:0]  req;
    logic        wr;
    logic [3:0]  grant;
    logic        busy;
    logic        done;
    logic        wr_out;
    logic [1:0]  id;
    logic [23:0] data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input int hp, input int dur);
    hp_bus[i*PERIOD_W +: PERIOD_W] = PERIOD_W'(hp);
    dur_bus[i*DUR_W +: DUR_W]      = DUR_W'(dur);
  endtask

  function automatic logic [23:0] exp_sample();
    if (!m_busy) return 24'd0;
    return (((m_sent / m_half) % 2) == 0) ? AMP : NEG;
  endfunction

  task automatic model_step();
    int win;
    win = -1;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i]) win = i;
    m_grant   = '0;
    m_done    = 1'b0;
    m_aborted = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
      m_id   = 0;
      m_sent = 0;
      m_half = 0;
      m_dur  = 0;
    end else if (win >= 0 && (!m_busy || win < m_id)) begin
      m_aborted = m_busy;
      m_grant   = NUM_REQ'(1 << win);
      m_id      = win;
      m_sent    = 0;
      m_half    = int'(hp_bus[win*PERIOD_W +: PERIOD_W]);
      m_dur     = int'(dur_bus[win*DUR_W +: DUR_W]);
      if (m_half != 0 && m_dur != 0) begin
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (m_busy && write_ready) begin
      m_sent++;
      if (m_sent == m_dur) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic compare_model();
    logic [23:0] ed;
    ed = exp_sample();
    check("grant",     32'(grant),           32'(m_grant));
    check("busy",      32'(busy),            32'(m_busy));
    check("active_id", 32'(active_id),       32'(m_id));
    check("done",      32'(done),            32'(m_done));
    check("aborted",   32'(aborted),         32'(m_aborted));
    check("write",     32'(write),           32'(m_busy && write_ready));
    check("data_l",    32'(writedata_left),  32'(ed));
    check("data_r",    32'(writedata_right), 32'(ed));
  endtask

  // One clock: score accepted sample at negedge, step model at posedge, compare 1 unit later.
  task automatic cycle();
    @(negedge clk);
    if (sb_on && write && write_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got %0h want none", writedata_left);
      end else begin
        check("sb_sample", 32'(writedata_left), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    check(name, 32'(done), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    reset       = 1'b1;
    req         = '0;
    hp_bus      = '0;
    dur_bus     = '0;
    write_ready = 1'b1;
    cycle();
    cycle();
    check("rst_ctrl", 32'({grant, busy, active_id, done, aborted, write}), 32'(0));
    check("rst_data", 32'(writedata_left), 32'(0));
    reset = 1'b0;
    cycle();

    // Basic tone: half period 2, duration 6 on slot 2.
    set_slot(2, 2, 6);
    vecs[0] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, AMP};
    vecs[1] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, AMP};
    vecs[2] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, NEG};
    vecs[3] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, NEG};
    vecs[4] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, AMP};
    vecs[5] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, AMP};
    vecs[6] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 24'd0};
    vecs[7] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 24'd0};
    for (int k = 0; k < 8; k++) begin
      req         = vecs[k].req;
      write_ready = vecs[k].wr;
      cycle();
      check("vec_grant", 32'(grant),          32'(vecs[k].grant));
      check("vec_busy",  32'(busy),           32'(vecs[k].busy));
      check("vec_done",  32'(done),           32'(vecs[k].done));
      check("vec_write", 32'(write),          32'(vecs[k].wr_out));
      check("vec_id",    32'(active_id),      32'(vecs[k].id));
      check("vec_data",  32'(writedata_left), 32'(vecs[k].data));
    end

    // Priority: 1 beats 3; 3 is granted the cycle after 1's done.
    set_slot(1, 3, 4);
    set_slot(3, 1, 3);
    req = 4'b1010;
    cycle();
    check("prio_grant1", 32'(grant), 32'(4'b0010));
    check("prio_id1", 32'(active_id), 32'(1));
    req = 4'b1000;
    wait_done(20, "prio_done1");
    check("prio_done_id1", 32'(active_id), 32'(1));
    cycle();
    check("prio_grant3", 32'(grant), 32'(4'b1000));
    check("prio_id3", 32'(active_id), 32'(3));
    req = 4'b0000;
    wait_done(20, "prio_done3");

    // Preemption: id 3 playing, id 0 arrives after 10 accepted samples.
    set_slot(3, 1, 100);
    set_slot(0, 3, 5);
    cycle();
    req = 4'b1000;
    cycle();
    req = 4'b0000;
    repeat (10) cycle();
    req = 4'b0001;
    cycle();
    check("pre_aborted", 32'(aborted), 32'(1));
    check("pre_grant0", 32'(grant), 32'(4'b0001));
    check("pre_no_done", 32'(done), 32'(0));
    check("pre_first", 32'(writedata_left), 32'(AMP));
    req = 4'b0000;
    exp_q = '{AMP, AMP, AMP, NEG, NEG};
    sb_on = 1'b1;
    wait_done(20, "pre_done0");
    check("pre_done_id", 32'(active_id), 32'(0));
    sb_on = 1'b0;
    check("pre_sb_drain", 32'(exp_q.size()), 32'(0));
    cycle();

    // Backpressure: write_ready toggles, same six samples.
    set_slot(2, 2, 6);
    exp_q = '{AMP, AMP, NEG, NEG, AMP, AMP};
    sb_on = 1'b1;
    req   = 4'b0100;
    cyc   = 0;
    do begin
      write_ready = cyc[0];
      cycle();
      cyc++;
      if (m_grant != '0) req = 4'b0000;
    end while (done !== 1'b1 && cyc < 40);
    check("bp_done", 32'(done), 32'(1));
    check("bp_cycles", 32'(cyc), 32'(12));
    sb_on = 1'b0;
    check("bp_sb_drain", 32'(exp_q.size()), 32'(0));
    write_ready = 1'b1;
    cycle();

    // Zero fields: grant and done together, no tone.
    for (int z = 0; z < 2; z++) begin
      if (z == 0) set_slot(1, 5, 0);
      else        set_slot(1, 0, 5);
      req = 4'b0010;
      cycle();
      check("zero_grant", 32'(grant), 32'(4'b0010));
      check("zero_done", 32'(done), 32'(1));
      check("zero_busy", 32'(busy), 32'(0));
      check("zero_write", 32'(write), 32'(0));
      req = 4'b0000;
      cycle();
      check("zero_idle_write", 32'(write), 32'(0));
    end

    // Reset mid-tone with the request held.
    set_slot(2, 2, 50);
    req = 4'b0100;
    repeat (4) cycle();
    reset = 1'b1;
    cycle();
    check("rstm_ctrl", 32'({grant, busy, active_id, done, aborted, write}), 32'(0));
    check("rstm_data", 32'(writedata_left), 32'(0));
    reset = 1'b0;
    cycle();
    check("rstm_regrant", 32'(grant), 32'(4'b0100));
    req = 4'b0000;
    wait_done(60, "rstm_done");

    // Randomized traffic checked every cycle against the model.
    for (int c = 0; c < 500; c++) begin
      req = req & ~m_grant;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i] && $urandom_range(7) == 0) begin
          set_slot(i,
                   ($urandom_range(9) == 0) ? 0 : int'($urandom_range(4, 1)),
                   ($urandom_range(9) == 0) ? 0 : int'($urandom_range(12, 1)));
          req[i] = 1'b1;
        end
      end
      write_ready = ($urandom_range(3) != 0);
      reset       = ($urandom_range(199) == 0);
      cycle();
    end
    reset       = 1'b0;
    req         = '0;
    write_ready = 1'b1;
    repeat (20) cycle();
    check("end_idle", 32'(busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_tone_arbiter.md
Name: audio_tone_arbiter

Overview:
- Shares the single audio CODEC write channel between NUM_REQ sound-effect requesters.
- Each requester asks for a square-wave tone, given as a half-period and a duration in samples.
- Arbitration is fixed-priority: index 0 is highest, and a higher-priority request preempts a playing tone.
- The block generates samples and drives the CODEC write/write_ready handshake, feeding both channels with identical data.

Parameters:
- NUM_REQ, 4, number of requesters; active_id width is clog2(NUM_REQ).
- PERIOD_W, 16, width of each half-period field, in samples.
- DUR_W, 20, width of each duration field, in samples.
- AMPLITUDE, 24'h0FFFFF, positive peak value; the negative half uses its 24-bit two's complement.

Ports:
- CLOCK_50 input 1: system clock; all logic is on the rising edge.
- reset input 1: synchronous, active-high reset.
- req input NUM_REQ: level request per requester, held until granted.
- req_half_period input NUM_REQ*PERIOD_W: packed half-periods; slot i is bits [i*PERIOD_W +: PERIOD_W].
- req_duration input NUM_REQ*DUR_W: packed durations; slot i is bits [i*DUR_W +: DUR_W].
- grant output NUM_REQ: one-hot, one-cycle pulse when a request is accepted.
- busy output 1: high while a tone is playing.
- active_id output clog2(NUM_REQ): index of the current or just-finished tone.
- done output 1: one-cycle pulse when a tone completes normally.
- aborted output 1: one-cycle pulse when a tone is preempted.
- write_ready input 1: CODEC can accept a sample.
- write output 1: CODEC write strobe.
- writedata_left output 24: sample for the left channel.
- writedata_right output 24: sample for the right channel, always equal to writedata_left.

Behaviour:
- Reset values:
  - grant, busy, done, aborted, active_id, write, writedata_* are all 0.
  - The FSM goes to IDLE; the phase and duration counters clear.
  - Reset mid-tone drops the tone with no done or aborted pulse.
- Sample acceptance: a sample is accepted in a cycle where write && write_ready.
  - write = busy && write_ready, combinational.
  - All counting advances only on accepted samples.
- States: IDLE, PLAY.
- IDLE:
  - If any req bit is high in cycle T, the lowest index i wins.
  - At edge T+1: latch half_period[i] and duration[i]; grant[i]=1 for one cycle; active_id=i; phase=positive; phase_cnt=0.
  - If both latched fields are nonzero: busy=1 and go to PLAY.
  - If either latched field is 0: grant and done pulse together in the same cycle, busy stays 0, and the FSM stays in IDLE.
- PLAY:
  - writedata_* = phase ? AMPLITUDE : -AMPLITUDE. The data is registered and valid whenever busy=1.
  - On each accepted sample: remaining decrements and phase_cnt increments.
  - When phase_cnt == half_period-1, phase_cnt resets to 0 and phase toggles; the new value applies to the next sample.
  - The first sample of every tone is +AMPLITUDE.
  - Accepted sample with remaining==1: at the next edge busy=0, done=1 for one cycle, go to IDLE. active_id keeps its value during the done cycle.
  - A new grant can occur at the earliest one cycle after done, because IDLE evaluates requests.
- Preemption:
  - In PLAY, if any req[j] is high with j < active_id, the next edge:
    - pulses aborted=1 and grant[j]=1;
    - loads j's fields, sets active_id=j, resets phase and phase_cnt;
    - keeps busy=1, or clears busy with done also pulsing if j's fields contain a zero.
  - A sample accepted in the same cycle belongs to the old tone and is discarded from the new tone's count.
- Equal- or lower-priority requests during PLAY wait; req[active_id] re-asserted mid-tone is ignored until IDLE.
- write_ready low stalls everything; tone timing is in accepted samples, not cycles.
- In IDLE, writedata_* is held at 0.

Test Plan:
- Basic tone: reset, then req[2]=1 with half_period=2 and duration=6, write_ready=1 constantly.
  - Required: grant=4'b0100 for one cycle, active_id=2.
  - Six accepted samples of 0FFFFF, 0FFFFF, F00001, F00001, 0FFFFF, 0FFFFF.
  - done pulses one cycle after the 6th sample, then busy=0 and write=0.
- Priority: req=4'b1010 asserted together from IDLE.
  - Required: grant=4'b0010 and active_id=1.
  - Req 3 is granted one cycle after req 1's done.
- Preemption: req[3] is playing (half_period=1, duration=100); assert req[0] after 10 accepted samples.
  - Required: aborted and grant[0] pulse in the same cycle, with no done for id 3.
  - The next sample is +AMPLITUDE, and id 0 completes its full duration.
- Backpressure: same setup as the basic tone, but write_ready toggles every other cycle.
  - Required: identical sample sequence; done arrives after the 6th accepted sample, about 12 cycles in.
- Zero fields: req[1] with duration=0.
  - Required: grant[1] and done pulse together, busy stays 0, no write occurs.
  - Repeat with half_period=0 for the same result.
- Reset mid-tone: assert reset during PLAY.
  - Required: next cycle all outputs are 0, with no done or aborted pulse.
  - A held req is re-granted one cycle after reset deasserts.
